rgmii_tx_framer: RTL and testbench

Transmit-side framer between the MAC byte stream and the RGMII output DDR stage. Accepts frames on a valid/ready/last byte interface, prepends preamble and SFD, optionally appends the Ethernet FCS, enforces the inter-packet gap and signals underrun as TX_ER. It drives nibble pairs and control pairs that feed the same-edge DDR output registers directly, one byte per clock.

---
 rtl/rgmii_pkg.sv | 30 +++
 rtl/rgmii_tx_crc32.sv | 35 +++
 rtl/rgmii_tx_framer.sv | 178 +++++++++++++++++
 tb/tb_rgmii_tx_framer.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/rgmii_pkg.sv
// rtl/rgmii_pkg.sv - shared states, framing constants and CRC-32 byte step for the RGMII transmit path
package rgmii_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PRE,
        ST_SFD,
        ST_DATA,
        ST_FCS,
        ST_ERR,
        ST_DRAIN,
        ST_IFG
    } tx_state_e;

    localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
    localparam logic [7:0]  SFD_BYTE      = 8'hD5;
    localparam logic [31:0] CRC32_POLY    = 32'hEDB88320;
    localparam logic [31:0] CRC32_INIT    = 32'hFFFFFFFF;

    // Reflected CRC-32, eight bit steps folded into one byte update
    function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] data);
        logic [31:0] c;
        c = crc ^ {24'd0, data};
        for (int i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ CRC32_POLY) : (c >> 1);
        end
        return c;
    endfunction

endpackage

// File: rtl/rgmii_tx_crc32.sv
// rtl/rgmii_tx_crc32.sv - byte-wise running CRC-32 register with clear and enable
module rgmii_tx_crc32
    import rgmii_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        clear,
    input  logic        enable,
    input  logic [7:0]  data,
    output logic [31:0] crc
);

    logic [31:0] crc_q;
    logic [31:0] crc_d;

    always_comb begin
        crc_d = crc_q;
        if (clear) begin
            crc_d = CRC32_INIT;
        end else if (enable) begin
            crc_d = crc32_byte(crc_q, data);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            crc_q <= CRC32_INIT;
        end else begin
            crc_q <= crc_d;
        end
    end

    assign crc = crc_q;

endmodule

// File: rtl/rgmii_tx_framer.sv
// rtl/rgmii_tx_framer.sv - RGMII transmit framer: preamble/SFD, optional FCS (RGMII_TX_FCS_EN), IFG, underrun as TX_ER
module rgmii_tx_framer
    import rgmii_pkg::*;
#(
    parameter int IFG_BYTES      = 12,
    parameter int PREAMBLE_BYTES = 7
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    input  logic       in_last,
    output logic       in_ready,
    output logic [3:0] txd_d1,
    output logic [3:0] txd_d2,
    output logic       ctl_d1,
    output logic       ctl_d2,
    output logic       busy
);

    localparam int CNT_MAX0 = (IFG_BYTES > PREAMBLE_BYTES) ? IFG_BYTES : PREAMBLE_BYTES;
    localparam int CNT_MAX  = (CNT_MAX0 > 4) ? CNT_MAX0 : 4;
    localparam int CNT_W    = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] PRE_LAST = CNT_W'(PREAMBLE_BYTES);
    localparam logic [CNT_W-1:0] IFG_LAST = CNT_W'(IFG_BYTES);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    tx_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [7:0]       byte_q, byte_d;
    logic             tx_en_q, tx_en_d;
    logic             tx_er_q, tx_er_d;
    logic             ready_q, ready_d;
    logic             busy_q, busy_d;

`ifdef RGMII_TX_FCS_EN
    localparam logic [CNT_W-1:0] FCS_LAST = CNT_W'(3);

    logic        crc_clear;
    logic        crc_en;
    logic [31:0] crc;
    logic [31:0] fcs_word;

    // CRC restarts on the edge that puts SFD on the wire
    assign crc_clear = (state_q == ST_PRE) && (cnt_q == PRE_LAST);
    assign crc_en    = ((state_q == ST_SFD) || (state_q == ST_DATA)) && in_valid;
    assign fcs_word  = ~crc;

    rgmii_tx_crc32 u_crc (
        .clock  (clock),
        .reset  (reset),
        .clear  (crc_clear),
        .enable (crc_en),
        .data   (in_data),
        .crc    (crc)
    );
`endif

    // Outputs are computed for the cycle being entered, so state_q is the
    // state that decides what the next wire cycle carries.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        byte_d  = 8'h00;
        tx_en_d = 1'b0;
        tx_er_d = 1'b0;
        ready_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    state_d = ST_PRE;
                    cnt_d   = CNT_ONE;
                    byte_d  = PREAMBLE_BYTE;
                    tx_en_d = 1'b1;
                end
            end
            ST_PRE: begin
                tx_en_d = 1'b1;
                if (cnt_q == PRE_LAST) begin
                    state_d = ST_SFD;
                    byte_d  = SFD_BYTE;
                    ready_d = 1'b1;
                end else begin
                    cnt_d  = cnt_q + CNT_ONE;
                    byte_d = PREAMBLE_BYTE;
                end
            end
            ST_SFD, ST_DATA: begin
                if (in_valid) begin
                    byte_d  = in_data;
                    tx_en_d = 1'b1;
                    cnt_d   = '0;
                    if (in_last) begin
`ifdef RGMII_TX_FCS_EN
                        state_d = ST_FCS;
`else
                        state_d = ST_IFG;
`endif
                    end else begin
                        state_d = ST_DATA;
                        ready_d = 1'b1;
                    end
                end else begin
                    state_d = ST_ERR;
                    tx_en_d = 1'b1;
                    tx_er_d = 1'b1;
                end
            end
`ifdef RGMII_TX_FCS_EN
            ST_FCS: begin
                tx_en_d = 1'b1;
                byte_d  = fcs_word[8*cnt_q[1:0] +: 8];
                if (cnt_q == FCS_LAST) begin
                    state_d = ST_IFG;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
`endif
            ST_ERR: begin
                state_d = ST_DRAIN;
                ready_d = 1'b1;
            end
            ST_DRAIN: begin
                // Entry cycle is already idle on the wire, so it counts as gap
                if (in_valid && in_last) begin
                    state_d = ST_IFG;
                    cnt_d   = CNT_ONE;
                end else begin
                    ready_d = 1'b1;
                end
            end
            ST_IFG: begin
                if (cnt_q == IFG_LAST) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            byte_q  <= 8'h00;
            tx_en_q <= 1'b0;
            tx_er_q <= 1'b0;
            ready_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            byte_q  <= byte_d;
            tx_en_q <= tx_en_d;
            tx_er_q <= tx_er_d;
            ready_q <= ready_d;
            busy_q  <= busy_d;
        end
    end

    assign txd_d1   = byte_q[3:0];
    assign txd_d2   = byte_q[7:4];
    assign ctl_d1   = tx_en_q;
    assign ctl_d2   = tx_en_q ^ tx_er_q;
    assign in_ready = ready_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_rgmii_tx_framer.sv
// tb/tb_rgmii_tx_framer.sv - scoreboard bench for rgmii_tx_framer
module tb_rgmii_tx_framer;

    localparam int P   = 7;
    localparam int IFG = 12;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] in_data = 8'h00;
    logic       in_valid = 1'b0;
    logic       in_last = 1'b0;
    logic       in_ready;
    logic [3:0] txd_d1, txd_d2;
    logic       ctl_d1, ctl_d2;
    logic       busy;

    rgmii_tx_framer #(.IFG_BYTES(IFG), .PREAMBLE_BYTES(P)) dut (
        .clock    (clock),
        .reset    (reset),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_last  (in_last),
        .in_ready (in_ready),
        .txd_d1   (txd_d1),
        .txd_d2   (txd_d2),
        .ctl_d1   (ctl_d1),
        .ctl_d2   (ctl_d2),
        .busy     (busy)
    );

    always #4 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int         errors = 0;
    int         checks = 0;
    logic [9:0] exp_q[$];
    bit         mon_en = 1'b0;
    int         last_act = -100;
    int         gap = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ref_fcs(input logic [7:0] b[$]);
        logic [31:0] c;
        c = 32'hFFFFFFFF;
        foreach (b[i]) begin
            for (int j = 0; j < 8; j++) begin
                if (c[0] ^ b[i][j]) c = (c >> 1) ^ 32'hEDB88320;
                else                c = c >> 1;
            end
        end
        return ~c;
    endfunction

    task automatic push_frame(input logic [7:0] b[$], input int drop, input bit fixed,
                              input logic [31:0] fixed_fcs);
        int          n;
        logic [31:0] fcs;
        for (int i = 0; i < P; i++) exp_q.push_back({2'b11, 8'h55});
        exp_q.push_back({2'b11, 8'hD5});
        n = (drop < 0) ? b.size() : drop;
        for (int i = 0; i < n; i++) exp_q.push_back({2'b11, b[i]});
        fcs = fixed ? fixed_fcs : ref_fcs(b);
        if (drop >= 0) begin
            exp_q.push_back({2'b10, 8'h00});
        end else begin
`ifdef RGMII_TX_FCS_EN
            for (int k = 0; k < 4; k++) exp_q.push_back({2'b11, fcs[8*k +: 8]});
`endif
        end
    endtask

    task automatic wait_accept(output int k);
        k = -1;
        for (int n = 0; n < 300; n++) begin
            @(negedge clock);
            if (in_ready) begin
                k = cyc;
                @(posedge clock);
                #1;
                return;
            end
        end
        check("accept_timeout", 32'd0, 32'd1);
    endtask

    task automatic send(input logic [7:0] b[$], input int drop, input bit hold, output int acc);
        acc = -1;
        for (int i = 0; i < b.size(); i++) begin
            if (i == drop) begin
                in_valid = 1'b0;
                @(posedge clock);
                #1;
            end
            in_valid = 1'b1;
            in_data  = b[i];
            in_last  = (i == b.size() - 1);
            wait_accept(acc);
        end
        if (!hold) begin
            in_valid = 1'b0;
            in_last  = 1'b0;
        end
    endtask

    task automatic wait_drained();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 400) begin
            @(negedge clock);
            n++;
        end
        if (exp_q.size() != 0) check("drain_timeout", exp_q.size(), 32'd0);
    endtask

    // ref_cyc < 0 means measure from the last active wire cycle
    task automatic finish_frame(input string tag, input int ref_cyc);
        int  r;
        int  n;
        bit  rdy;
        wait_drained();
        r   = (ref_cyc < 0) ? last_act : ref_cyc;
        rdy = 1'b0;
        n   = 0;
        do begin
            @(negedge clock);
            if (in_ready && cyc > r) rdy = 1'b1;
            n++;
        end while (busy && n < 200);
        check({tag, "_busy_fall"}, cyc, r + IFG + 1);
        check({tag, "_ifg_ready"}, {31'd0, rdy}, 32'd0);
    endtask

    initial begin
        logic [7:0] fa[$];
        logic [7:0] fs[$];
        logic [7:0] fu[$];
        logic [7:0] fb[$];
        logic [7:0] fc[$];
        logic [7:0] fr[$];
        int         acc;

        fork
            forever begin
                logic [9:0] e;
                @(negedge clock);
                if (mon_en && !reset) begin
                    if (ctl_d1 || ctl_d2) begin
                        if (cyc != last_act + 1) gap = cyc - last_act;
                        last_act = cyc;
                        if (exp_q.size() == 0) begin
                            check("unexpected_active", {22'd0, ctl_d1, ctl_d2, txd_d2, txd_d1}, 32'd0);
                        end else begin
                            e = exp_q.pop_front();
                            check("wire", {22'd0, ctl_d1, ctl_d2, txd_d2, txd_d1}, {22'd0, e});
                        end
                    end else begin
                        check("idle_txd", {24'd0, txd_d2, txd_d1}, 32'd0);
                    end
                end
            end
        join_none

        repeat (3) @(posedge clock);
        #1;
        check("reset_outputs", {22'd0, busy, in_ready, ctl_d1, ctl_d2, txd_d2, txd_d1}, 32'd0);
        @(negedge clock);
        reset  = 1'b0;
        mon_en = 1'b1;
        @(posedge clock);
        #1;

        fa = '{8'h01, 8'h02, 8'h03, 8'h04};
        push_frame(fa, -1, 1'b0, 32'd0);
        send(fa, -1, 1'b0, acc);
        finish_frame("frame_a", -1);

        fs = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
        push_frame(fs, -1, 1'b1, 32'hCBF43926);
        send(fs, -1, 1'b0, acc);
        finish_frame("check_str", -1);

        fu = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h14, 8'h15};
        push_frame(fu, 3, 1'b0, 32'd0);
        send(fu, 3, 1'b0, acc);
        check("underrun_done", {31'd0, acc >= 0}, 32'd1);
        finish_frame("underrun", acc);

        fb = '{8'hA1, 8'hA2, 8'hA3};
        fc = '{8'hB1, 8'hB2};
        push_frame(fb, -1, 1'b0, 32'd0);
        push_frame(fc, -1, 1'b0, 32'd0);
        send(fb, -1, 1'b1, acc);
        send(fc, -1, 1'b0, acc);
        wait_drained();
        check("b2b_gap", gap, IFG + 2);
        finish_frame("b2b", -1);

        mon_en   = 1'b0;
        in_valid = 1'b1;
        in_last  = 1'b0;
        in_data  = 8'h5A;
        wait_accept(acc);
        in_data = 8'h5B;
        wait_accept(acc);
        #1;
        reset = 1'b1;
        #1;
        check("async_reset", {22'd0, busy, in_ready, ctl_d1, ctl_d2, txd_d2, txd_d1}, 32'd0);
        in_valid = 1'b0;
        repeat (2) @(negedge clock);
        reset = 1'b0;
        exp_q.delete();
        mon_en = 1'b1;
        @(posedge clock);
        #1;

        fr = '{8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h00, 8'hFF};
        push_frame(fr, -1, 1'b0, 32'd0);
        send(fr, -1, 1'b0, acc);
        finish_frame("post_reset", -1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
